// File: rtl/hazard_stall_ctrl.sv
// Hazard controller for the 5-stage core: load-use bubbles, EX redirects and
// mult/div occupancy, with a saturating count of front-end stall cycles.
module hazard_stall_ctrl #(
    parameter int MD_LATENCY = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_md_start,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_redirect,
    output logic             pc_write,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int MW = $clog2(MD_LATENCY);
    localparam logic [MW-1:0] MD_LOAD = MW'(MD_LATENCY - 1);

    typedef enum logic {
        RUN,
        MD_WAIT
    } state_t;

    state_t        state, state_n;
    logic [MW-1:0] md_cnt, md_cnt_n;
    logic          load_use;

    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_comb begin
        state_n     = state;
        md_cnt_n    = md_cnt;
        pc_write    = 1'b1;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        md_busy     = 1'b0;
        md_done     = 1'b0;

        if (reset) begin
            // Hold the front end and flush both pipeline registers while in reset
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_n     = RUN;
            md_cnt_n    = '0;
        end else begin
            case (state)
                RUN: begin
                    if (ex_redirect) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (id_md_start) begin
                        md_cnt_n = MD_LOAD;
                        state_n  = MD_WAIT;
                    end
                end
                MD_WAIT: begin
                    md_busy = 1'b1;
                    if (ex_redirect) begin
                        // The mult/div belonged to a squashed path: abort silently
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        md_cnt_n    = '0;
                        state_n     = RUN;
                    end else if (md_cnt != '0) begin
                        pc_write    = 1'b0;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                        md_cnt_n    = md_cnt - 1'b1;
                    end else begin
                        md_done = 1'b1;
                        state_n = RUN;
                    end
                end
                default: begin
                    state_n  = RUN;
                    md_cnt_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            md_cnt       <= '0;
            stall_cycles <= '0;
        end else begin
            state  <= state_n;
            md_cnt <= md_cnt_n;
            if (!pc_write && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomized bench for hazard_stall_ctrl (MD_LATENCY=4, CNT_W=4) checked
// against a cycle-level reference model tracking mult/div age since issue.
module tb_hazard_stall_ctrl;

    localparam int LAT   = 4;
    localparam int CW    = 4;
    localparam int MAXC  = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic [4:0]    id_rs;
    logic [4:0]    id_rt;
    logic          id_uses_rt;
    logic          id_md_start;
    logic          ex_mem_read;
    logic [4:0]    ex_rt;
    logic          ex_redirect;
    logic          pc_write;
    logic          if_id_stall;
    logic          if_id_flush;
    logic          id_ex_flush;
    logic          md_busy;
    logic          md_done;
    logic [CW-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    // Reference model: whether a mult/div is outstanding and how many cycles ago it issued
    bit m_busy;
    int m_age;
    int m_cnt;

    hazard_stall_ctrl #(.MD_LATENCY(LAT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_md_start(id_md_start), .ex_mem_read(ex_mem_read),
        .ex_rt(ex_rt), .ex_redirect(ex_redirect),
        .pc_write(pc_write), .if_id_stall(if_id_stall),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .md_busy(md_busy), .md_done(md_done), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [5:0] ctrl_vec();
        return {pc_write, if_id_stall, if_id_flush, id_ex_flush, md_busy, md_done};
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_age  = 0;
        m_cnt  = 0;
    endtask

    // Starts just after a falling edge and returns at the next falling edge
    task automatic apply_stimulus(input logic [4:0] rs, input logic [4:0] rt,
                                  input logic urt, input logic md, input logic mr,
                                  input logic [4:0] ert, input logic redir);
        logic       lu;
        logic [5:0] exp_ctrl;
        id_rs = rs; id_rt = rt; id_uses_rt = urt; id_md_start = md;
        ex_mem_read = mr; ex_rt = ert; ex_redirect = redir;
        lu = mr && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
        if (!m_busy) begin
            if (redir)   exp_ctrl = 6'b101100;
            else if (lu) exp_ctrl = 6'b010100;
            else         exp_ctrl = 6'b100000;
        end else begin
            if (redir)            exp_ctrl = 6'b101110;
            else if (m_age < LAT) exp_ctrl = 6'b010110;
            else                  exp_ctrl = 6'b100011;
        end
        #1;
        check_output("ctrl", 32'(ctrl_vec()), 32'(exp_ctrl));
        @(posedge clk);
        if (!exp_ctrl[5] && m_cnt < MAXC) m_cnt++;
        if (!m_busy) begin
            if (!redir && !lu && md) begin
                m_busy = 1;
                m_age  = 1;
            end
        end else if (redir || m_age == LAT) begin
            m_busy = 0;
        end else begin
            m_age++;
        end
        #1;
        check_output("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    // Asynchronous reset pulse spanning two rising edges, released at a falling edge
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check_output("rst_ctrl", 32'(ctrl_vec()), 32'(6'b001100));
        check_output("rst_cnt", 32'(stall_cycles), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_output("rst_done", 32'(md_done), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b1;
        id_rs = 0; id_rt = 0; id_uses_rt = 0; id_md_start = 0;
        ex_mem_read = 0; ex_rt = 0; ex_redirect = 0;
        model_reset();
        #3;
        check_output("init_ctrl", 32'(ctrl_vec()), 32'(6'b001100));
        check_output("init_cnt", 32'(stall_cycles), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Load-use on rs: a single bubble
        apply_stimulus(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
        idle(2);
        check_output("t1_cnt", 32'(stall_cycles), 32'd1);

        // Register 0 never causes a hazard
        do_reset();
        apply_stimulus(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0);
        idle(1);
        check_output("t2_cnt", 32'(stall_cycles), 32'd0);

        // Load-use via rt only when rt is a source
        apply_stimulus(5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0);
        apply_stimulus(5'd3, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0);

        // Redirect beats load-use
        apply_stimulus(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1);
        idle(1);

        // Mult/div occupancy
        apply_stimulus(5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        idle(LAT + 1);

        // Redirect aborts an outstanding mult/div
        apply_stimulus(5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        idle(1);
        apply_stimulus(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        idle(LAT);

        // Reset during the second cycle of a mult/div
        apply_stimulus(5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        idle(1);
        do_reset();
        check_output("t5_cnt", 32'(stall_cycles), 32'd0);
        idle(LAT + 2);

        // Saturation of the stall counter
        do_reset();
        for (int i = 0; i < 20; i++) apply_stimulus(5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0);
        check_output("t6_sat", 32'(stall_cycles), 32'(MAXC));

        // Randomized traffic with frequent register matches
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 59) do_reset();
            apply_stimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
                           1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
                           1'($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
